// File: rtl/moving_average_pkg.sv
// Shared types and width helpers for the moving-average window filter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package moving_average_pkg;

    // Run-time averaging mode: one output per input once primed, or one per window.
    typedef enum logic {
        MA_SLIDING = 1'b0,
        MA_BLOCK   = 1'b1
    } ma_mode_e;

    // Window occupancy state, derived from the fill count.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } ma_state_e;

    // Running-sum width: W samples of N bits can never overflow N+LOG2_WIN bits.
    function automatic int sum_width(input int n, input int log2_win);
        return n + log2_win;
    endfunction

    // Half an LSB of the shifted result, added before the shift for round-half-up.
    function automatic int round_term(input int log2_win);
        return (log2_win > 0) ? (1 << (log2_win - 1)) : 0;
    endfunction

endpackage

// File: rtl/ma_sample_ring.sv
// W x N sample ring with write pointer; presents the oldest sample (the one about to be overwritten).
// Latency: write takes effect on the clock edge; oldest_o is combinational from registers.
// Backpressure: none; clr_i wins over wr_en_i and zeroes every slot so oldest reads 0 while filling.
module ma_sample_ring #(
    parameter int N        = 16,
    parameter int LOG2_WIN = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          wr_en_i,
    input  logic [N-1:0]  wr_dat_i,
    output logic [N-1:0]  oldest_o
);

    localparam int W = 1 << LOG2_WIN;

    logic [N-1:0]          ring_q [W];
    logic [LOG2_WIN-1:0]   wr_ptr_q;
    logic [LOG2_WIN-1:0]   wr_ptr_d;

    // Pointer wraps naturally because its width is exactly log2 of the window.
    always_comb begin
        wr_ptr_d = wr_ptr_q + LOG2_WIN'(1);
    end

    // Zero the ring on reset or flush, otherwise store the new sample over the oldest.
    always_ff @(posedge clk) begin
        if (!rst || clr_i) begin
            wr_ptr_q <= '0;
            for (int i = 0; i < W; i++) begin
                ring_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            ring_q[wr_ptr_q] <= wr_dat_i;
            wr_ptr_q         <= wr_ptr_d;
        end
    end

    assign oldest_o = ring_q[wr_ptr_q];

endmodule

// File: rtl/moving_average_window.sv
// Sliding / block moving-average filter over W = 2^LOG2_WIN unsigned samples, optional round-half-up.
// Latency: 1 cycle from the accepting edge to the isFiltered pulse; all outputs registered.
// Backpressure: none; every fit_data sample is taken unless clear or a mode change drops it.
module moving_average_window
    import moving_average_pkg::*;
#(
    parameter int N        = 16,
    parameter int LOG2_WIN = 2,
    parameter int ROUND    = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  data_in,
    input  logic          fit_data,
    input  logic          mode,
    input  logic          clear,
    output logic          isFiltered,
    output logic [N-1:0]  data_out,
    output logic          primed
);

    localparam int              SW      = sum_width(N, LOG2_WIN);
    localparam int              CW      = LOG2_WIN + 1;
    localparam logic [CW-1:0]   WCNT    = CW'(1 << LOG2_WIN);
    localparam logic [SW:0]     RND_ADD = (SW + 1)'((ROUND != 0) ? round_term(LOG2_WIN) : 0);

    logic [SW-1:0]  sum_q;
    logic [CW-1:0]  cnt_q;
    ma_state_e      st_q;
    ma_mode_e       mode_q;
    logic [N-1:0]   data_out_q;
    logic           filt_q;
    logic           primed_q;

    logic [N-1:0]   oldest;
    logic [SW-1:0]  sum_acc;
    logic [CW-1:0]  cnt_acc;
    logic [SW:0]    rnd_sum;
    logic [N:0]     shifted;
    logic [N-1:0]   avg_res;
    logic           mode_chg;
    logic           win_done;
    logic           ring_clr;
    logic           ring_wr;

    ma_sample_ring #(
        .N        (N),
        .LOG2_WIN (LOG2_WIN)
    ) u_ring (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (ring_clr),
        .wr_en_i  (ring_wr),
        .wr_dat_i (data_in),
        .oldest_o (oldest)
    );

    // Candidate sum/count for an accept, and the (optionally rounded, saturated) average.
    always_comb begin
        sum_acc  = sum_q + SW'(data_in) - SW'(oldest);
        cnt_acc  = (st_q == ST_FULL) ? WCNT : cnt_q + CW'(1);
        rnd_sum  = {1'b0, sum_acc} + RND_ADD;
        shifted  = (N + 1)'(rnd_sum >> LOG2_WIN);
        avg_res  = shifted[N] ? '1 : shifted[N-1:0];
        mode_chg = (mode != mode_q);
        win_done = fit_data && (cnt_acc == WCNT);
        // Flushes beat the write; a completed block also empties the ring on the same edge.
        ring_clr = clear || mode_chg || (win_done && (mode_q == MA_BLOCK));
        ring_wr  = fit_data && !clear && !mode_chg;
    end

    // Window state machine: priority reset > clear > mode change > accept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sum_q      <= '0;
            cnt_q      <= '0;
            st_q       <= ST_FILL;
            mode_q     <= MA_SLIDING;
            data_out_q <= '0;
            filt_q     <= 1'b0;
            primed_q   <= 1'b0;
        end else if (clear || mode_chg) begin
            // data_out is deliberately held across a flush.
            if (mode_chg) begin
                mode_q <= ma_mode_e'(mode);
            end
            sum_q    <= '0;
            cnt_q    <= '0;
            st_q     <= ST_FILL;
            filt_q   <= 1'b0;
            primed_q <= 1'b0;
        end else if (fit_data) begin
            if (win_done) begin
                data_out_q <= avg_res;
                filt_q     <= 1'b1;
                if (mode_q == MA_BLOCK) begin
                    sum_q    <= '0;
                    cnt_q    <= '0;
                    st_q     <= ST_FILL;
                    primed_q <= 1'b0;
                end else begin
                    sum_q    <= sum_acc;
                    cnt_q    <= cnt_acc;
                    st_q     <= ST_FULL;
                    primed_q <= 1'b1;
                end
            end else begin
                sum_q  <= sum_acc;
                cnt_q  <= cnt_acc;
                filt_q <= 1'b0;
            end
        end else begin
            filt_q <= 1'b0;
        end
    end

    assign isFiltered = filt_q;
    assign data_out   = data_out_q;
    assign primed     = primed_q;

endmodule

// File: tb/tb_moving_average_window.sv
// Bench for moving_average_window: three instances (W=4 floor, W=4 rounded, W=8 floor) share stimulus.
// Instance 0 is scoreboarded against a sample-history model; all three get scenario checks.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_moving_average_window;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic        fit_data;
    logic        mode;
    logic        clear;

    logic        f0, f1, f2;
    logic [15:0] d0, d1, d2;
    logic        p0, p1, p2;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_cnt = 0;
    int exp_q[$];
    int hist[$];
    logic m_mode = 1'b0;
    int mon_exp;

    always #5 clk = ~clk;

    moving_average_window #(.N(16), .LOG2_WIN(2), .ROUND(0)) dut0 (
        .clk(clk), .rst(rst_n), .data_in(data_in), .fit_data(fit_data), .mode(mode),
        .clear(clear), .isFiltered(f0), .data_out(d0), .primed(p0));
    moving_average_window #(.N(16), .LOG2_WIN(2), .ROUND(1)) dut1 (
        .clk(clk), .rst(rst_n), .data_in(data_in), .fit_data(fit_data), .mode(mode),
        .clear(clear), .isFiltered(f1), .data_out(d1), .primed(p1));
    moving_average_window #(.N(16), .LOG2_WIN(3), .ROUND(0)) dut2 (
        .clk(clk), .rst(rst_n), .data_in(data_in), .fit_data(fit_data), .mode(mode),
        .clear(clear), .isFiltered(f2), .data_out(d2), .primed(p2));

    // Scoreboard: every dut0 pulse pops one expected average.
    always @(negedge clk) begin
        if (f0 === 1'b1) begin
            pulse_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected_pulse: got data_out=%0d, required no pulse", d0);
            end else begin
                mon_exp = exp_q.pop_front();
                if (d0 !== 16'(mon_exp)) begin
                    n_bad++;
                    $display("FAIL sb_data_out: got %0d, required %0d", d0, mon_exp);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One cycle of stimulus plus the reference model update for dut0 (W=4, floor).
    task automatic drive(input logic v, input int d, input logic clr, input logic m);
        @(posedge clk); #1;
        fit_data = v; data_in = 16'(d); clear = clr; mode = m;
        if (clr) begin
            hist.delete();
        end else if (m != m_mode) begin
            m_mode = m;
            hist.delete();
        end else if (v) begin
            hist.push_back(d);
            if (hist.size() == 4) begin
                int s;
                s = 0;
                foreach (hist[i]) s += hist[i];
                exp_q.push_back(s / 4);
                if (m_mode) hist.delete();
                else void'(hist.pop_front());
            end
        end
    endtask

    task automatic samp(input int d);
        drive(1'b1, d, 1'b0, mode);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 1'b0, mode);
    endtask

    task automatic flush();
        drive(1'b0, 0, 1'b1, mode);
    endtask

    // Hold reset for some edges; returns 1 unit after the last reset edge with reset released.
    task automatic do_reset(input int cycles, input logic fit, input int d);
        @(posedge clk); #1;
        rst_n = 1'b0; fit_data = fit; data_in = 16'(d); clear = 1'b0; mode = 1'b0;
        hist.delete();
        m_mode = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1; fit_data = 1'b0;
    endtask

    task automatic test_reset();
        int pc;
        do_reset(2, 1'b1, 'h1234);
        n_cmp++; if (f0 !== 1'b0) begin n_bad++; $display("FAIL reset_isFiltered: got %b, required 0", f0); end
        n_cmp++; if (d0 !== 16'h0) begin n_bad++; $display("FAIL reset_data_out: got %h, required 0000", d0); end
        n_cmp++; if (p0 !== 1'b0) begin n_bad++; $display("FAIL reset_primed: got %b, required 0", p0); end
        n_cmp++; if ({f1, p1, d1, f2, p2, d2} !== 36'h0) begin n_bad++;
            $display("FAIL reset_other_instances: got %h, required 0", {f1, p1, d1, f2, p2, d2}); end
        pc = pulse_cnt;
        samp('h1234); samp('h1234); samp('h1234);
        idle(2);
        n_cmp++; if (pulse_cnt !== pc) begin n_bad++;
            $display("FAIL reset_no_early_pulse: got %0d pulses, required 0", pulse_cnt - pc); end
    endtask

    task automatic test_sliding();
        int pc;
        int vals[6] = '{4, 8, 12, 16, 20, 24};
        flush();
        pc = pulse_cnt;
        samp(4); samp(8); samp(12);
        idle(1); @(negedge clk);
        n_cmp++; if (p0 !== 1'b0) begin n_bad++; $display("FAIL slide_primed_early: got %b, required 0", p0); end
        samp(16);
        idle(1); @(negedge clk);
        n_cmp++; if (p0 !== 1'b1) begin n_bad++; $display("FAIL slide_primed_rise: got %b, required 1", p0); end
        n_cmp++; if (d0 !== 16'd10) begin n_bad++; $display("FAIL slide_first_avg: got %0d, required 10", d0); end
        samp(20); samp(24);
        idle(2);
        n_cmp++; if (pulse_cnt - pc !== 3) begin n_bad++;
            $display("FAIL slide_pulse_count: got %0d, required 3", pulse_cnt - pc); end
        n_cmp++; if (d0 !== 16'd18) begin n_bad++; $display("FAIL slide_last_avg: got %0d, required 18", d0); end
        // Same sequence with two idle cycles between samples.
        flush();
        pc = pulse_cnt;
        foreach (vals[i]) begin
            samp(vals[i]);
            idle(2);
        end
        n_cmp++; if (pulse_cnt - pc !== 3) begin n_bad++;
            $display("FAIL gap_pulse_count: got %0d, required 3", pulse_cnt - pc); end
        n_cmp++; if (d0 !== 16'd18 || p0 !== 1'b1) begin n_bad++;
            $display("FAIL gap_final: got data_out=%0d primed=%b, required 18 and 1", d0, p0); end
    endtask

    task automatic test_block();
        int pc;
        drive(1'b0, 0, 1'b0, 1'b1);
        pc = pulse_cnt;
        for (int i = 1; i <= 8; i++) begin
            samp(i);
            @(negedge clk);
            n_cmp++; if (p0 !== 1'b0) begin n_bad++; $display("FAIL block_primed: got %b, required 0", p0); end
        end
        idle(2);
        n_cmp++; if (pulse_cnt - pc !== 2) begin n_bad++;
            $display("FAIL block_pulse_count: got %0d, required 2", pulse_cnt - pc); end
        n_cmp++; if (d0 !== 16'd6) begin n_bad++; $display("FAIL block_last_avg: got %0d, required 6", d0); end
        n_cmp++; if (d2 !== 16'd4) begin n_bad++; $display("FAIL block_w8_avg: got %0d, required 4", d2); end
    endtask

    task automatic test_round();
        drive(1'b0, 0, 1'b0, 1'b0);
        repeat (4) samp('hFFFF);
        idle(1); @(negedge clk);
        n_cmp++; if (d0 !== 16'hFFFF) begin n_bad++; $display("FAIL max_floor: got %h, required ffff", d0); end
        n_cmp++; if (d1 !== 16'hFFFF) begin n_bad++; $display("FAIL max_round: got %h, required ffff", d1); end
        flush();
        samp(1); samp(1); samp(2); samp(2);
        idle(1); @(negedge clk);
        n_cmp++; if (d0 !== 16'd1) begin n_bad++; $display("FAIL floor_1122: got %0d, required 1", d0); end
        n_cmp++; if (d1 !== 16'd2) begin n_bad++; $display("FAIL round_1122: got %0d, required 2", d1); end
        flush();
        for (int i = 0; i < 8; i++) samp(i);
        idle(1); @(negedge clk);
        n_cmp++; if (d2 !== 16'd3 || f2 !== 1'b1) begin n_bad++;
            $display("FAIL w8_avg: got data_out=%0d pulse=%b, required 3 and 1", d2, f2); end
        idle(1);
    endtask

    task automatic test_clear();
        flush();
        samp(4); samp(8);
        drive(1'b1, 100, 1'b1, 1'b0);
        samp(1); samp(1); samp(1); samp(1);
        idle(1); @(negedge clk);
        n_cmp++; if (d0 !== 16'd1 || f0 !== 1'b1) begin n_bad++;
            $display("FAIL clear_drop: got data_out=%0d pulse=%b, required 1 and 1", d0, f0); end
        idle(1);
    endtask

    task automatic test_mode_toggle();
        flush();
        samp(4); samp(8);
        drive(1'b1, 100, 1'b0, 1'b1);
        idle(1); @(negedge clk);
        n_cmp++; if (d0 !== 16'd1 || f0 !== 1'b0) begin n_bad++;
            $display("FAIL toggle_hold: got data_out=%0d pulse=%b, required 1 and 0", d0, f0); end
        samp(2); samp(2); samp(2); samp(2);
        idle(1); @(negedge clk);
        n_cmp++; if (d0 !== 16'd2 || f0 !== 1'b1) begin n_bad++;
            $display("FAIL toggle_avg: got data_out=%0d pulse=%b, required 2 and 1", d0, f0); end
        drive(1'b0, 0, 1'b0, 1'b0);
        idle(1);
    endtask

    task automatic test_reset_mid();
        int pc;
        flush();
        samp(3); samp(5); samp(7);
        do_reset(1, 1'b0, 0);
        n_cmp++; if ({f0, p0, d0} !== 18'h0) begin n_bad++;
            $display("FAIL midreset_outputs: got %h, required 0", {f0, p0, d0}); end
        pc = pulse_cnt;
        samp(8); samp(8); samp(8);
        idle(1); @(negedge clk);
        n_cmp++; if (f0 !== 1'b0) begin n_bad++; $display("FAIL midreset_early: got %b, required 0", f0); end
        samp(8);
        idle(1); @(negedge clk);
        n_cmp++; if (d0 !== 16'd8 || f0 !== 1'b1) begin n_bad++;
            $display("FAIL midreset_avg: got data_out=%0d pulse=%b, required 8 and 1", d0, f0); end
        idle(1);
        n_cmp++; if (pulse_cnt - pc !== 1) begin n_bad++;
            $display("FAIL midreset_pulse_count: got %0d, required 1", pulse_cnt - pc); end
    endtask

    initial begin
        rst_n = 1'b0; data_in = '0; fit_data = 1'b0; mode = 1'b0; clear = 1'b0;
        test_reset();
        test_sliding();
        test_block();
        test_round();
        test_clear();
        test_mode_toggle();
        test_reset_mid();
        idle(2);
        n_cmp++; if (exp_q.size() != 0) begin n_bad++;
            $display("FAIL sb_drain: got %0d outstanding, required 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/moving_average_window.md
Name: moving_average_window

Overview:
- Parametrised sliding-window moving-average filter for the sensor/data pre-conditioning path that sits ahead of the cryptoprocessor datapath.
- Generalises the fixed 4-sample block averager:
  - window size is a power of two, set by a parameter;
  - data width is parametrised;
  - run-time selection between sliding mode (one output per input once primed) and block/decimating mode (one output per window);
  - optional rounding;
  - synchronous clear.
- Keeps a sample ring buffer and a running sum, so each output costs one add and one subtract.

Parameters:
- N, 16, sample and output width in bits.
- LOG2_WIN, 2, log2 of window size; W = 2^LOG2_WIN; legal range 1..6.
- ROUND, 0, 0 = truncate (floor); 1 = round half up (add 2^(LOG2_WIN-1) before the shift).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-low reset.
- data_in  input  N  unsigned sample.
- fit_data  input  1  sample valid; data_in is accepted on each clk edge where this is high.
- mode  input  1  0 = sliding, 1 = block.
- clear  input  1  synchronous flush of window state; active high.
- isFiltered  output  1  one-cycle pulse; data_out is valid.
- data_out  output  N  averaged value; holds its last value between pulses.
- primed  output  1  high while the window holds W valid samples (sliding mode).

Behaviour:
- Reset (rst low at a clk edge) clears the following to 0: isFiltered, data_out, primed, running sum, fill count, write pointer, ring contents, and the registered mode (mode_q).
- Reset mid-window discards all partial state.
- Widths:
  - running sum is N+LOG2_WIN bits and can never overflow;
  - fill count is LOG2_WIN+1 bits and saturates at W;
  - result is (sum_next [+ round term]) >> LOG2_WIN. With ROUND=1 this addition uses one extra bit and the result saturates at 2^N-1.
- Accept cycle (fit_data high and no clear/mode-change event):
  - oldest = ring[wr_ptr];
  - sum_next = sum + data_in - oldest;
  - ring[wr_ptr] <= data_in;
  - wr_ptr increments modulo W;
  - fill count increments, saturating at W.
  - The ring is zeroed at reset/clear, so oldest = 0 during fill.
- State machine (fill-count derived):
  - FILL: count < W.
  - FULL: count == W.
  - FILL -> FULL: on the accept that makes count == W.
  - FULL -> FILL: only on clear, mode change, or reset.
- Sliding mode (mode_q = 0):
  - on every accept where count_next == W: data_out <= result and isFiltered <= 1 on the same edge (latency 1 cycle from the accepting edge);
  - primed = (count == W).
- Block mode (mode_q = 1):
  - on the accept where count_next == W: output as in sliding mode, then sum, count, wr_ptr and the ring are cleared on that same edge;
  - primed is held 0.
- No accept:
  - isFiltered <= 0;
  - all state holds;
  - arbitrary gaps in fit_data are legal.
- Clear (priority over accept):
  - same clearing as reset, except data_out and mode_q keep their values;
  - isFiltered <= 0;
  - a coincident fit_data sample is dropped.
- Mode change (mode != mode_q at a clk edge):
  - mode_q <= mode;
  - state cleared as for clear;
  - the coincident sample is dropped;
  - isFiltered <= 0.
- Priority order: rst > clear > mode change > accept.
- Outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package moving_average_pkg:
  - mode enum (MA_SLIDING = 0, MA_BLOCK = 1);
  - function sum_width(N, LOG2_WIN);
  - function round_term(LOG2_WIN).
- One sub-module, ma_sample_ring:
  - W x N register ring, write pointer, synchronous zeroing clear;
  - returns the oldest sample combinationally.
- Sum, count, mode tracking and output registers stay in the top module.

Test Plan (N = 16, LOG2_WIN = 2 unless noted):
- Reset: drive rst = 0 for 2 cycles with fit_data = 1, data_in = 0x1234 -> isFiltered = 0, data_out = 0, primed = 0; after release the next 3 samples produce no pulse.
- Sliding: samples 4, 8, 12, 16, 20, 24 back to back -> no pulse for the first 3; then pulses with data_out 10, 14, 18; primed rises with the first pulse. Repeat with 2-cycle fit_data gaps -> same values, one pulse per accept.
- Block: mode = 1, samples 1..8 -> exactly two pulses, data_out 2 then 6 (sums 10 and 26); primed stays 0.
- Saturation/rounding:
  - four samples of 0xFFFF -> 0xFFFF, with both ROUND = 0 and ROUND = 1;
  - samples 1, 1, 2, 2 -> 1 with ROUND = 0, 2 with ROUND = 1;
  - LOG2_WIN = 3, samples 0..7 -> 3 with ROUND = 0.
- Clear/mode change mid-window:
  - sliding, samples 4, 8, then clear with fit_data = 1 and data_in = 100 -> 100 is dropped; the next samples 1, 1, 1, 1 -> data_out 1;
  - toggling mode after 2 samples behaves identically, and data_out keeps its prior value.
- Reset mid-window: 3 samples accepted, then rst pulse -> all outputs 0; the next 4 samples of 8 -> data_out 8 on the 4th, with no stale contribution.
